// File: rtl/hazard_unit_mc_if.sv
// ---------------------------------------------------------------------------
// hazard_unit_mc_if
//   Bundle of every signal exchanged between the 5-stage pipeline (plus the
//   multi-cycle mul/div unit) and the hazard/forwarding controller.
//
//   master : pipeline side. It drives the D/E/M/W register fields and the
//            multi-cycle unit status. It receives the forwarding selects,
//            the stall/flush controls and the scoreboard view.
//   slave  : hazard_unit_mc side. It has the opposite directions.
//
//   Parameters
//     NUM_REGS : number of architectural registers (x0 hardwired to zero)
//     REG_AW   : register address width, clog2(NUM_REGS)
// ---------------------------------------------------------------------------
interface hazard_unit_mc_if #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5
);

  // Decode stage
  logic [REG_AW-1:0]   rs1D_addr_i;
  logic [REG_AW-1:0]   rs2D_addr_i;
  logic                rs1D_used_i;
  logic                rs2D_used_i;
  logic [REG_AW-1:0]   rdD_addr_i;
  logic                rdD_wr_ena_i;
  logic                mcD_i;

  // Execute stage
  logic [REG_AW-1:0]   rs1E_addr_i;
  logic [REG_AW-1:0]   rs2E_addr_i;
  logic [REG_AW-1:0]   rdE_addr_i;
  logic                loadE_i;
  logic                mc_issueE_i;

  // Memory / writeback stages
  logic [REG_AW-1:0]   rdM_addr_i;
  logic                rdM_wr_ena_i;
  logic [REG_AW-1:0]   rdW_addr_i;
  logic                rdW_wr_ena_i;

  // Multi-cycle unit completion and branch resolution
  logic                mc_done_i;
  logic [REG_AW-1:0]   mc_rd_addr_i;
  logic                wrong_branch_i;

  // Controller outputs
  logic [1:0]          forwardAE_o;
  logic [1:0]          forwardBE_o;
  logic                stallF_o;
  logic                stallD_o;
  logic                flushD_o;
  logic                flushE_o;
  logic                mc_busy_o;
  logic [NUM_REGS-1:0] pending_o;

  modport master (
    output rs1D_addr_i, rs2D_addr_i, rs1D_used_i, rs2D_used_i,
    output rdD_addr_i, rdD_wr_ena_i, mcD_i,
    output rs1E_addr_i, rs2E_addr_i, rdE_addr_i, loadE_i, mc_issueE_i,
    output rdM_addr_i, rdM_wr_ena_i, rdW_addr_i, rdW_wr_ena_i,
    output mc_done_i, mc_rd_addr_i, wrong_branch_i,
    input  forwardAE_o, forwardBE_o, stallF_o, stallD_o,
    input  flushD_o, flushE_o, mc_busy_o, pending_o
  );

  modport slave (
    input  rs1D_addr_i, rs2D_addr_i, rs1D_used_i, rs2D_used_i,
    input  rdD_addr_i, rdD_wr_ena_i, mcD_i,
    input  rs1E_addr_i, rs2E_addr_i, rdE_addr_i, loadE_i, mc_issueE_i,
    input  rdM_addr_i, rdM_wr_ena_i, rdW_addr_i, rdW_wr_ena_i,
    input  mc_done_i, mc_rd_addr_i, wrong_branch_i,
    output forwardAE_o, forwardBE_o, stallF_o, stallD_o,
    output flushD_o, flushE_o, mc_busy_o, pending_o
  );

endinterface

// File: rtl/hazard_unit_mc.sv
// ---------------------------------------------------------------------------
// hazard_unit_mc
//   Hazard and forwarding controller for the 5-stage RISC-V pipeline. It
//   works with one multi-cycle execution unit (mul/div).
//
//   Functions
//     - E-stage operand forwarding from M (highest priority) and W.
//     - Load-use stall that inserts LOAD_STALL bubbles, counted in ld_cnt_q.
//     - A per-register scoreboard of results still owed by the multi-cycle
//       unit. It gives RAW and WAW stalls for the D-stage instruction.
//     - A structural stall when a multi-cycle op reaches D while the unit
//       is busy.
//     - Operand-used qualifiers, so that an unused rs field never stalls.
//     - Branch mispredict flush. It has priority over every stall.
//
//   Ports
//     clk_i, rst_i : clock and asynchronous active-high reset
//     hz           : hazard_unit_mc_if.slave. It carries the pipeline
//                    fields, the multi-cycle unit status, the forwarding
//                    selects (00 regfile, 01 W, 10 M), the stall/flush
//                    controls, mc_busy_o and the pending_o scoreboard view.
//
//   Parameters
//     NUM_REGS   : architectural registers (x0 hardwired zero)
//     REG_AW     : register address width, must equal clog2(NUM_REGS)
//     LOAD_STALL : bubbles per load-use hazard, 1..15
// ---------------------------------------------------------------------------
module hazard_unit_mc #(
  parameter int NUM_REGS   = 32,
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  hazard_unit_mc_if.slave  hz
);

  // Reject illegal parameter sets at elaboration time.
  if (REG_AW != $clog2(NUM_REGS)) begin : g_bad_reg_aw
    $error("hazard_unit_mc: REG_AW must equal clog2(NUM_REGS)");
  end
  if ((LOAD_STALL < 1) || (LOAD_STALL > 15)) begin : g_bad_load_stall
    $error("hazard_unit_mc: LOAD_STALL must be in 1..15");
  end

  localparam logic [3:0] LD_RELOAD = 4'(LOAD_STALL - 1);

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Forwarding select for one E-stage source. M is checked before W so that
  // the younger in-flight value wins. x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic              wen_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              wen_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (wen_m && (rs == rd_m)) begin
        sel = 2'b10;
      end else if (wen_w && (rs == rd_w)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  // True when the D-stage instruction really reads register r. x0 never
  // hits, because reading it can never depend on an older instruction.
  function automatic logic src_hit(
    input logic [REG_AW-1:0] r,
    input logic [REG_AW-1:0] a1,
    input logic              u1,
    input logic [REG_AW-1:0] a2,
    input logic              u2
  );
    return (r != '0) && ((u1 && (a1 == r)) || (u2 && (a2 == r)));
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                busy_q,    busy_d;
  logic [3:0]          ld_cnt_q,  ld_cnt_d;

  logic ld_hit;
  logic ld_stall;
  logic sb_stall;
  logic mc_stall;
  logic stall;

  // -------------------------------------------------------------------------
  // Forwarding
  // -------------------------------------------------------------------------
  assign hz.forwardAE_o = fwd_sel(hz.rs1E_addr_i, hz.rdM_addr_i, hz.rdM_wr_ena_i,
                                  hz.rdW_addr_i, hz.rdW_wr_ena_i);
  assign hz.forwardBE_o = fwd_sel(hz.rs2E_addr_i, hz.rdM_addr_i, hz.rdM_wr_ena_i,
                                  hz.rdW_addr_i, hz.rdW_wr_ena_i);

  // -------------------------------------------------------------------------
  // Hazard detection
  // -------------------------------------------------------------------------

  // A new load-use hazard is only recognised when the counter is idle. While
  // the counter runs, the load has already moved on and E holds a bubble.
  assign ld_hit   = hz.loadE_i
                  && src_hit(hz.rdE_addr_i, hz.rs1D_addr_i, hz.rs1D_used_i,
                             hz.rs2D_addr_i, hz.rs2D_used_i)
                  && (ld_cnt_q == 4'd0);
  assign ld_stall = ld_hit || (ld_cnt_q != 4'd0);

  // The scoreboard stall looks only at registered pending bits. A result
  // that completes this cycle is still stalled on. The D instruction reads
  // the regfile one cycle later, so it then sees the written value.
  always_comb begin
    sb_stall = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (pending_q[r]
          && (src_hit(REG_AW'(r), hz.rs1D_addr_i, hz.rs1D_used_i,
                      hz.rs2D_addr_i, hz.rs2D_used_i)
              || (hz.rdD_wr_ena_i && (hz.rdD_addr_i == REG_AW'(r))))) begin
        sb_stall = 1'b1;
      end
    end
  end

  assign mc_stall = hz.mcD_i && busy_q;
  assign stall    = ld_stall || sb_stall || mc_stall;

  // -------------------------------------------------------------------------
  // Stall / flush controls
  // -------------------------------------------------------------------------

  // A mispredict discards the wrong-path D instruction. A stall of that
  // instruction is therefore pointless, so the flush overrides it.
  always_comb begin
    hz.stallF_o = 1'b0;
    hz.stallD_o = 1'b0;
    hz.flushD_o = 1'b0;
    hz.flushE_o = 1'b0;
    if (hz.wrong_branch_i) begin
      hz.flushD_o = 1'b1;
      hz.flushE_o = 1'b1;
    end else begin
      hz.stallF_o = stall;
      hz.stallD_o = stall;
      hz.flushE_o = stall;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    ld_cnt_d = 4'd0;
    if (hz.wrong_branch_i) begin
      ld_cnt_d = 4'd0;
    end else if (ld_hit) begin
      ld_cnt_d = LD_RELOAD;
    end else if (ld_cnt_q != 4'd0) begin
      ld_cnt_d = ld_cnt_q - 4'd1;
    end
  end

  // The clear is applied before the set, so an issue to the register that
  // completes in the same cycle keeps its bit. The scoreboard is never
  // flushed by a mispredict, because the issuing instruction was already
  // valid in E.
  always_comb begin
    pending_d = pending_q;
    if (hz.mc_done_i) begin
      pending_d[hz.mc_rd_addr_i] = 1'b0;
    end
    if (hz.mc_issueE_i && (hz.rdE_addr_i != '0)) begin
      pending_d[hz.rdE_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // An issue in the same cycle as a completion leaves the unit occupied.
  assign busy_d = hz.mc_issueE_i || (busy_q && !hz.mc_done_i);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
      busy_q    <= 1'b0;
      ld_cnt_q  <= 4'd0;
    end else begin
      pending_q <= pending_d;
      busy_q    <= busy_d;
      ld_cnt_q  <= ld_cnt_d;
    end
  end

  assign hz.mc_busy_o = busy_q;
  assign hz.pending_o = pending_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
module tb_hazard_unit_mc;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  // a: LOAD_STALL=1, b: LOAD_STALL=3
  hazard_unit_mc_if #(.NUM_REGS(32), .REG_AW(5)) ia ();
  hazard_unit_mc_if #(.NUM_REGS(32), .REG_AW(5)) ib ();

  hazard_unit_mc #(.NUM_REGS(32), .REG_AW(5), .LOAD_STALL(1)) u_a (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (ia)
  );

  hazard_unit_mc #(.NUM_REGS(32), .REG_AW(5), .LOAD_STALL(3)) u_b (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    ia.rs1D_addr_i = '0; ia.rs2D_addr_i = '0; ia.rs1D_used_i = 0; ia.rs2D_used_i = 0;
    ia.rdD_addr_i = '0; ia.rdD_wr_ena_i = 0; ia.mcD_i = 0;
    ia.rs1E_addr_i = '0; ia.rs2E_addr_i = '0; ia.rdE_addr_i = '0;
    ia.loadE_i = 0; ia.mc_issueE_i = 0;
    ia.rdM_addr_i = '0; ia.rdM_wr_ena_i = 0; ia.rdW_addr_i = '0; ia.rdW_wr_ena_i = 0;
    ia.mc_done_i = 0; ia.mc_rd_addr_i = '0; ia.wrong_branch_i = 0;
    ib.rs1D_addr_i = '0; ib.rs2D_addr_i = '0; ib.rs1D_used_i = 0; ib.rs2D_used_i = 0;
    ib.rdD_addr_i = '0; ib.rdD_wr_ena_i = 0; ib.mcD_i = 0;
    ib.rs1E_addr_i = '0; ib.rs2E_addr_i = '0; ib.rdE_addr_i = '0;
    ib.loadE_i = 0; ib.mc_issueE_i = 0;
    ib.rdM_addr_i = '0; ib.rdM_wr_ena_i = 0; ib.rdW_addr_i = '0; ib.rdW_wr_ena_i = 0;
    ib.mc_done_i = 0; ib.mc_rd_addr_i = '0; ib.wrong_branch_i = 0;
  endtask

  // ctl vectors below are {stallF, stallD, flushD, flushE}
  task automatic test_reset;
    logic [3:0] ctl;
    rst = 1'b1;
    idle_all();
    #2;
    ctl = {ia.stallF_o, ia.stallD_o, ia.flushD_o, ia.flushE_o};
    n_cmp++; if (ctl !== 4'b0000) begin n_fail++; $display("FAIL rst_a_ctl got=%b exp=0000", ctl); end
    ctl = {ib.stallF_o, ib.stallD_o, ib.flushD_o, ib.flushE_o};
    n_cmp++; if (ctl !== 4'b0000) begin n_fail++; $display("FAIL rst_b_ctl got=%b exp=0000", ctl); end
    n_cmp++; if ({ia.forwardAE_o, ia.forwardBE_o} !== 4'b0000) begin n_fail++; $display("FAIL rst_fwd got=%b exp=0000", {ia.forwardAE_o, ia.forwardBE_o}); end
    n_cmp++; if (ia.pending_o !== 32'h0) begin n_fail++; $display("FAIL rst_pending got=%h exp=0", ia.pending_o); end
    n_cmp++; if ({ia.mc_busy_o, ib.mc_busy_o} !== 2'b00) begin n_fail++; $display("FAIL rst_busy got=%b exp=00", {ia.mc_busy_o, ib.mc_busy_o}); end
    tick(); tick();
    rst = 1'b0;
    tick();
    ctl = {ia.stallF_o, ia.stallD_o, ia.flushD_o, ia.flushE_o};
    n_cmp++; if ({ctl, ia.mc_busy_o} !== 5'b0) begin n_fail++; $display("FAIL post_rst_a got=%b exp=00000", {ctl, ia.mc_busy_o}); end
  endtask

  task automatic test_forward;
    idle_all();
    ia.rs1E_addr_i = 5'd5; ia.rdM_addr_i = 5'd5; ia.rdM_wr_ena_i = 1; ia.rdW_addr_i = 5'd5; ia.rdW_wr_ena_i = 1;
    #1;
    n_cmp++; if (ia.forwardAE_o !== 2'b10) begin n_fail++; $display("FAIL fwd_m_prio got=%b exp=10", ia.forwardAE_o); end
    ia.rdM_wr_ena_i = 0;
    #1;
    n_cmp++; if (ia.forwardAE_o !== 2'b01) begin n_fail++; $display("FAIL fwd_w_when_m_off got=%b exp=01", ia.forwardAE_o); end
    ia.rs1E_addr_i = 5'd0; ia.rdM_addr_i = 5'd0; ia.rdM_wr_ena_i = 1; ia.rdW_addr_i = 5'd0;
    #1;
    n_cmp++; if (ia.forwardAE_o !== 2'b00) begin n_fail++; $display("FAIL fwd_x0 got=%b exp=00", ia.forwardAE_o); end
    ia.rs1E_addr_i = 5'd6; ia.rs2E_addr_i = 5'd7; ia.rdM_addr_i = 5'd6; ia.rdW_addr_i = 5'd7;
    #1;
    n_cmp++; if (ia.forwardBE_o !== 2'b01) begin n_fail++; $display("FAIL fwd_b_w got=%b exp=01", ia.forwardBE_o); end
    n_cmp++; if (ia.forwardAE_o !== 2'b10) begin n_fail++; $display("FAIL fwd_a_m got=%b exp=10", ia.forwardAE_o); end
    idle_all();
  endtask

  task automatic test_load_use_1;
    logic [3:0] ctl;
    idle_all();
    tick();
    ia.loadE_i = 1; ia.rdE_addr_i = 5'd3; ia.rs1D_addr_i = 5'd3; ia.rs1D_used_i = 1;
    #1;
    ctl = {ia.stallF_o, ia.stallD_o, ia.flushD_o, ia.flushE_o};
    n_cmp++; if (ctl !== 4'b1101) begin n_fail++; $display("FAIL ld1_hit got=%b exp=1101", ctl); end
    tick();
    ia.loadE_i = 0; ia.rdE_addr_i = 5'd0;
    #1;
    ctl = {ia.stallF_o, ia.stallD_o, ia.flushD_o, ia.flushE_o};
    n_cmp++; if (ctl !== 4'b0000) begin n_fail++; $display("FAIL ld1_one_cycle got=%b exp=0000", ctl); end
    ia.loadE_i = 1; ia.rdE_addr_i = 5'd3; ia.rs1D_used_i = 0;
    #1;
    ctl = {ia.stallF_o, ia.stallD_o, ia.flushD_o, ia.flushE_o};
    n_cmp++; if (ctl !== 4'b0000) begin n_fail++; $display("FAIL ld1_unused got=%b exp=0000", ctl); end
    idle_all();
    tick();
  endtask

  task automatic test_load_use_3;
    logic [3:0] ctl;
    idle_all();
    ib.loadE_i = 1; ib.rdE_addr_i = 5'd3; ib.rs2D_addr_i = 5'd3; ib.rs2D_used_i = 1;
    #1;
    ctl = {ib.stallF_o, ib.stallD_o, ib.flushD_o, ib.flushE_o};
    n_cmp++; if (ctl !== 4'b1101) begin n_fail++; $display("FAIL ld3_c1 got=%b exp=1101", ctl); end
    tick();
    ib.loadE_i = 0; ib.rdE_addr_i = 5'd0;
    #1;
    ctl = {ib.stallF_o, ib.stallD_o, ib.flushD_o, ib.flushE_o};
    n_cmp++; if (ctl !== 4'b1101) begin n_fail++; $display("FAIL ld3_c2 got=%b exp=1101", ctl); end
    tick();
    ctl = {ib.stallF_o, ib.stallD_o, ib.flushD_o, ib.flushE_o};
    n_cmp++; if (ctl !== 4'b1101) begin n_fail++; $display("FAIL ld3_c3 got=%b exp=1101", ctl); end
    tick();
    ctl = {ib.stallF_o, ib.stallD_o, ib.flushD_o, ib.flushE_o};
    n_cmp++; if (ctl !== 4'b0000) begin n_fail++; $display("FAIL ld3_c4 got=%b exp=0000", ctl); end
    // second hazard, mispredict arrives in its second cycle
    ib.loadE_i = 1; ib.rdE_addr_i = 5'd3;
    #1;
    ctl = {ib.stallF_o, ib.stallD_o, ib.flushD_o, ib.flushE_o};
    n_cmp++; if (ctl !== 4'b1101) begin n_fail++; $display("FAIL ld3_br_c1 got=%b exp=1101", ctl); end
    tick();
    ib.loadE_i = 0; ib.rdE_addr_i = 5'd0; ib.wrong_branch_i = 1;
    #1;
    ctl = {ib.stallF_o, ib.stallD_o, ib.flushD_o, ib.flushE_o};
    n_cmp++; if (ctl !== 4'b0011) begin n_fail++; $display("FAIL ld3_br_flush got=%b exp=0011", ctl); end
    tick();
    ib.wrong_branch_i = 0;
    #1;
    ctl = {ib.stallF_o, ib.stallD_o, ib.flushD_o, ib.flushE_o};
    n_cmp++; if (ctl !== 4'b0000) begin n_fail++; $display("FAIL ld3_br_cnt_clr got=%b exp=0000", ctl); end
    idle_all();
    tick();
  endtask

  task automatic test_scoreboard;
    logic [3:0] ctl;
    idle_all();
    ia.mc_issueE_i = 1; ia.rdE_addr_i = 5'd10;
    #1;
    n_cmp++; if ({ia.mc_busy_o, ia.pending_o} !== 33'h0) begin n_fail++; $display("FAIL sb_pre_issue busy=%b pend=%h exp=0/0", ia.mc_busy_o, ia.pending_o); end
    tick();
    ia.mc_issueE_i = 0; ia.rdE_addr_i = 5'd0;
    #1;
    n_cmp++; if (ia.pending_o !== 32'h0000_0400) begin n_fail++; $display("FAIL sb_pending got=%h exp=00000400", ia.pending_o); end
    n_cmp++; if (ia.mc_busy_o !== 1'b1) begin n_fail++; $display("FAIL sb_busy got=%b exp=1", ia.mc_busy_o); end
    ia.rs1D_addr_i = 5'd10; ia.rs1D_used_i = 1;
    #1;
    ctl = {ia.stallF_o, ia.stallD_o, ia.flushD_o, ia.flushE_o};
    n_cmp++; if (ctl !== 4'b1101) begin n_fail++; $display("FAIL sb_raw got=%b exp=1101", ctl); end
    tick();
    ctl = {ia.stallF_o, ia.stallD_o, ia.flushD_o, ia.flushE_o};
    n_cmp++; if (ctl !== 4'b1101) begin n_fail++; $display("FAIL sb_raw_hold got=%b exp=1101", ctl); end
    ia.mc_done_i = 1; ia.mc_rd_addr_i = 5'd10;
    #1;
    ctl = {ia.stallF_o, ia.stallD_o, ia.flushD_o, ia.flushE_o};
    n_cmp++; if (ctl !== 4'b1101) begin n_fail++; $display("FAIL sb_done_cycle got=%b exp=1101", ctl); end
    tick();
    ia.mc_done_i = 0; ia.mc_rd_addr_i = 5'd0;
    #1;
    ctl = {ia.stallF_o, ia.stallD_o, ia.flushD_o, ia.flushE_o};
    n_cmp++; if ({ctl, ia.mc_busy_o, ia.pending_o} !== 37'h0) begin n_fail++; $display("FAIL sb_after_done ctl=%b busy=%b pend=%h exp=0000/0/0", ctl, ia.mc_busy_o, ia.pending_o); end
    idle_all();
  endtask

  task automatic test_waw_struct;
    logic [3:0] ctl;
    idle_all();
    ia.mc_issueE_i = 1; ia.rdE_addr_i = 5'd10;
    tick();
    ia.mc_issueE_i = 0; ia.rdE_addr_i = 5'd0;
    ia.rdD_addr_i = 5'd10; ia.rdD_wr_ena_i = 1;
    #1;
    ctl = {ia.stallF_o, ia.stallD_o, ia.flushD_o, ia.flushE_o};
    n_cmp++; if (ctl !== 4'b1101) begin n_fail++; $display("FAIL waw got=%b exp=1101", ctl); end
    ia.rdD_wr_ena_i = 0;
    #1;
    ctl = {ia.stallF_o, ia.stallD_o, ia.flushD_o, ia.flushE_o};
    n_cmp++; if (ctl !== 4'b0000) begin n_fail++; $display("FAIL waw_no_wen got=%b exp=0000", ctl); end
    ia.rdD_addr_i = 5'd11; ia.mcD_i = 1;
    #1;
    ctl = {ia.stallF_o, ia.stallD_o, ia.flushD_o, ia.flushE_o};
    n_cmp++; if (ctl !== 4'b1101) begin n_fail++; $display("FAIL struct got=%b exp=1101", ctl); end
    ia.mcD_i = 0; ia.rdD_addr_i = 5'd0;
    // issue x12 while x10 completes
    ia.mc_issueE_i = 1; ia.rdE_addr_i = 5'd12; ia.mc_done_i = 1; ia.mc_rd_addr_i = 5'd10;
    tick();
    ia.mc_issueE_i = 0; ia.rdE_addr_i = 5'd0; ia.mc_done_i = 0; ia.mc_rd_addr_i = 5'd0;
    #1;
    n_cmp++; if ({ia.mc_busy_o, ia.pending_o} !== {1'b1, 32'h0000_1000}) begin n_fail++; $display("FAIL issue_done busy=%b pend=%h exp=1/00001000", ia.mc_busy_o, ia.pending_o); end
    // same-register collision: set wins
    ia.mc_issueE_i = 1; ia.rdE_addr_i = 5'd12; ia.mc_done_i = 1; ia.mc_rd_addr_i = 5'd12;
    tick();
    ia.mc_issueE_i = 0; ia.rdE_addr_i = 5'd0; ia.mc_done_i = 0; ia.mc_rd_addr_i = 5'd0;
    #1;
    n_cmp++; if ({ia.mc_busy_o, ia.pending_o} !== {1'b1, 32'h0000_1000}) begin n_fail++; $display("FAIL collision busy=%b pend=%h exp=1/00001000", ia.mc_busy_o, ia.pending_o); end
    ia.mc_done_i = 1; ia.mc_rd_addr_i = 5'd12;
    tick();
    ia.mc_done_i = 0; ia.mc_rd_addr_i = 5'd0;
    #1;
    n_cmp++; if ({ia.mc_busy_o, ia.pending_o} !== 33'h0) begin n_fail++; $display("FAIL drain busy=%b pend=%h exp=0/0", ia.mc_busy_o, ia.pending_o); end
    // done for a register that is not pending
    ia.mc_done_i = 1; ia.mc_rd_addr_i = 5'd20;
    tick();
    ia.mc_done_i = 0; ia.mc_rd_addr_i = 5'd0;
    #1;
    n_cmp++; if ({ia.mc_busy_o, ia.pending_o} !== 33'h0) begin n_fail++; $display("FAIL stray_done busy=%b pend=%h exp=0/0", ia.mc_busy_o, ia.pending_o); end
    // issue to x0 occupies the unit but marks nothing
    ia.mc_issueE_i = 1; ia.rdE_addr_i = 5'd0;
    tick();
    ia.mc_issueE_i = 0;
    #1;
    n_cmp++; if ({ia.mc_busy_o, ia.pending_o} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL issue_x0 busy=%b pend=%h exp=1/0", ia.mc_busy_o, ia.pending_o); end
    ia.mc_done_i = 1;
    tick();
    ia.mc_done_i = 0;
    idle_all();
  endtask

  task automatic test_reset_mid;
    logic [3:0] ctl;
    idle_all();
    ib.mc_issueE_i = 1; ib.rdE_addr_i = 5'd4;
    tick();
    ib.mc_issueE_i = 0;
    ib.loadE_i = 1; ib.rdE_addr_i = 5'd3; ib.rs1D_addr_i = 5'd3; ib.rs1D_used_i = 1;
    tick();
    ib.loadE_i = 0; ib.rdE_addr_i = 5'd0; ib.rs1D_used_i = 0; ib.rs1D_addr_i = 5'd0;
    #1;
    ctl = {ib.stallF_o, ib.stallD_o, ib.flushD_o, ib.flushE_o};
    n_cmp++; if ({ctl, ib.mc_busy_o, ib.pending_o} !== {4'b1101, 1'b1, 32'h0000_0010}) begin n_fail++; $display("FAIL mid_pre ctl=%b busy=%b pend=%h exp=1101/1/00000010", ctl, ib.mc_busy_o, ib.pending_o); end
    #1;
    rst = 1'b1;
    #1;
    ctl = {ib.stallF_o, ib.stallD_o, ib.flushD_o, ib.flushE_o};
    n_cmp++; if ({ctl, ib.mc_busy_o, ib.pending_o} !== 37'h0) begin n_fail++; $display("FAIL mid_async ctl=%b busy=%b pend=%h exp=0000/0/0", ctl, ib.mc_busy_o, ib.pending_o); end
    tick();
    rst = 1'b0;
    tick();
    ctl = {ib.stallF_o, ib.stallD_o, ib.flushD_o, ib.flushE_o};
    n_cmp++; if ({ctl, ib.mc_busy_o} !== 5'b0) begin n_fail++; $display("FAIL mid_release ctl=%b busy=%b exp=0000/0", ctl, ib.mc_busy_o); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_forward();
    test_load_use_1();
    test_load_use_3();
    test_scoreboard();
    test_waw_struct();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Next-generation hazard/forwarding controller for the 5-stage RISC-V pipeline.
- Keeps the E-stage operand forwarding from M and W.
- Adds a parametrised multi-cycle load-use stall counter.
- Adds a per-register scoreboard for one multi-cycle execution unit (mul/div), giving RAW, WAW and structural stalls.
- Adds operand-used qualifiers to remove false stalls.
- Sits between the decode/execute pipeline registers and the multi-cycle unit.
- Drives the stall and flush controls of the F/D/E registers.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is hardwired zero.
- REG_AW, 5, register address width; must equal clog2(NUM_REGS).
- LOAD_STALL, 1, number of bubbles inserted on a load-use hazard; legal range 1..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- rs1D_addr_i  in  REG_AW  D-stage source 1
- rs2D_addr_i  in  REG_AW  D-stage source 2
- rs1D_used_i  in  1  D instruction reads rs1
- rs2D_used_i  in  1  D instruction reads rs2
- rdD_addr_i  in  REG_AW  D-stage destination
- rdD_wr_ena_i  in  1  D instruction writes rd
- mcD_i  in  1  D instruction is a multi-cycle op
- rs1E_addr_i  in  REG_AW  E-stage source 1
- rs2E_addr_i  in  REG_AW  E-stage source 2
- rdE_addr_i  in  REG_AW  E-stage destination
- loadE_i  in  1  E instruction is a load
- mc_issueE_i  in  1  E instruction is dispatched to the multi-cycle unit this cycle
- rdM_addr_i  in  REG_AW  M-stage destination
- rdM_wr_ena_i  in  1  M writes rd
- rdW_addr_i  in  REG_AW  W-stage destination
- rdW_wr_ena_i  in  1  W writes rd
- mc_done_i  in  1  multi-cycle result is written to the regfile this cycle
- mc_rd_addr_i  in  REG_AW  destination of the completing multi-cycle op
- wrong_branch_i  in  1  E-stage branch mispredict
- forwardAE_o  out  2  00 regfile, 01 W, 10 M
- forwardBE_o  out  2  same encoding as forwardAE_o
- stallF_o  out  1  hold PC
- stallD_o  out  1  hold F/D register
- flushD_o  out  1  clear F/D register
- flushE_o  out  1  clear D/E register (bubble)
- mc_busy_o  out  1  multi-cycle unit occupied
- pending_o  out  NUM_REGS  scoreboard bits, for debug and verification

Behaviour:
- State:
  - pending_q[NUM_REGS]
  - busy_q
  - ld_cnt_q (4 bit)
  - All cleared asynchronously on rst_i.
  - During and after reset with idle inputs, all outputs are 0.
- Forwarding (combinational), per operand X in {A,B} with source rsXE:
  - Output 10 if rsXE==rdM_addr_i & rdM_wr_ena_i & rsXE!=0.
  - Otherwise 01 if rsXE==rdW_addr_i & rdW_wr_ena_i & rsXE!=0.
  - Otherwise 00. M has priority over W.
- Source-match qualifier:
  - srcD_hit(r) = (rs1D_used_i & rs1D_addr_i==r) | (rs2D_used_i & rs2D_addr_i==r).
  - r==0 never hits.
- Load-use detect:
  - ld_hit = loadE_i & srcD_hit(rdE_addr_i) & ld_cnt_q==0.
  - On ld_hit: ld_cnt_d = LOAD_STALL-1.
  - While ld_cnt_q!=0: ld_cnt_d = ld_cnt_q-1.
  - ld_stall = ld_hit | (ld_cnt_q!=0).
- Scoreboard stall:
  - sb_stall = any r with pending_q[r] & (srcD_hit(r) | (rdD_wr_ena_i & rdD_addr_i==r)). Covers RAW and WAW.
  - Uses registered pending_q only; the cycle of mc_done_i still stalls.
- Structural stall: mc_stall = mcD_i & busy_q.
- Scoreboard update, each cycle:
  - mc_done_i clears pending[mc_rd_addr_i].
  - mc_issueE_i & rdE_addr_i!=0 sets pending[rdE_addr_i].
  - Set wins on a same-register collision.
  - pending[0] is always 0.
- busy_q update:
  - busy_d = mc_issueE_i | (busy_q & ~mc_done_i).
  - Issue and done in the same cycle leaves busy at 1.
  - mc_busy_o = busy_q.
- Stall/flush outputs, with stall = ld_stall | sb_stall | mc_stall:
  - If wrong_branch_i: flushD=1, flushE=1, stallF=stallD=0, ld_cnt_d=0. Branch has priority; the wrong-path D instruction is discarded.
  - Otherwise: stallF=stallD=stall, flushE=stall, flushD=0.
- The scoreboard is never cleared by wrong_branch_i. The issuing instruction is in E and is architecturally valid.
- mc_done_i for a register that is not pending: clear is a no-op, no error.

Test Plan:
- Forward priority: rs1E=5, rdM=5/wen, rdW=5/wen -> forwardAE=10. Same with rs1E=0 -> 00. rs2E=7 matching W only -> forwardBE=01.
- Load-use, LOAD_STALL=1: loadE, rdE=3, rs1D=3 used -> stallF/stallD/flushE=1 for exactly 1 cycle. Same with rs1D_used=0 -> no stall.
- Load-use, LOAD_STALL=3: same hazard -> stall held 3 consecutive cycles. wrong_branch in cycle 2 -> flushD=flushE=1, stall drops, ld_cnt_q=0 next cycle.
- Scoreboard: mc_issueE, rdE=10 -> pending_o[10]=1, busy=1. D reads x10 -> stall until mc_done_i with rd=10. Stall still 1 in the done cycle, 0 the following cycle.
- WAW/structural: pending x10, D writes x10 -> stall. mcD_i while busy -> stall. Issue and done same cycle -> busy stays 1, new bit set.
- Reset mid-operation: pending x4, busy, ld_cnt=2, assert rst_i asynchronously -> pending_o=0, mc_busy_o=0, all stall/flush outputs 0 immediately.
